// File: rtl/square_unit_arbiter_if.sv
// Request/response bundle for the shared squaring engine.
// Slave side is the arbiter; master side is the requesters plus consumer.
interface square_unit_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int IN_W    = 3,
  parameter int ID_W    = 2
);
  localparam int OUT_W = 2 * IN_W;

  logic [NUM_REQ-1:0]      req_valid;
  logic [NUM_REQ*IN_W-1:0] req_data;
  logic [NUM_REQ-1:0]      req_ready;
  logic                    rsp_valid;
  logic [OUT_W-1:0]        rsp_data;
  logic [ID_W-1:0]         rsp_id;
  logic                    rsp_ready;
  logic                    busy;

  modport master (
    output req_valid, req_data, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_id, busy
  );

  modport slave (
    input  req_valid, req_data, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_id, busy
  );
endinterface

// File: rtl/square_unit_arbiter.sv
// Round-robin arbiter in front of one shift-add squaring engine.
// One operand bit per cycle; result held until the consumer takes it.
module square_unit_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IN_W    = 3,
  parameter int ID_W    = 2
) (
  input logic                 clk,
  input logic                 rst_n,
  square_unit_arbiter_if.slave bus
);
  localparam int OUT_W = 2 * IN_W;
  localparam int CNT_W = $clog2(IN_W + 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COMPUTE = 2'd1,
    S_RESP    = 2'd2
  } state_t;

  state_t           r_state;
  logic [IN_W-1:0]  r_a;
  logic [ID_W-1:0]  r_id;
  logic [ID_W-1:0]  r_last;
  logic [OUT_W-1:0] r_acc;
  logic [CNT_W-1:0] r_cnt;
  logic             r_rsp_valid;
  logic [OUT_W-1:0] r_rsp_data;
  logic [ID_W-1:0]  r_rsp_id;
  logic             r_busy;

  logic             w_any;
  logic [ID_W-1:0]  w_gidx;
  logic [ID_W-1:0]  w_cand;
  logic             w_grant;
  logic [IN_W-1:0]  w_opnd;
  logic [IN_W-1:0]  w_shift;
  logic [OUT_W-1:0] w_acc_nxt;

  // Search starts just after the last winner, so it ranks lowest.
  always_comb begin
    int j;
    w_any  = 1'b0;
    w_gidx = '0;
    w_cand = '0;
    j      = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      j      = (int'(r_last) + k) % NUM_REQ;
      w_cand = ID_W'(j);
      if (!w_any && bus.req_valid[w_cand]) begin
        w_any  = 1'b1;
        w_gidx = w_cand;
      end
    end
  end

  assign w_grant = rst_n && (r_state == S_IDLE) && w_any;
  assign w_opnd  = bus.req_data[w_gidx*IN_W +: IN_W];

  assign w_shift   = r_a >> r_cnt;
  assign w_acc_nxt = r_acc +
    (w_shift[0] ? (OUT_W'(r_a) << r_cnt) : '0);

  assign bus.req_ready =
    w_grant ? (NUM_REQ'(1) << w_gidx) : '0;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_data  = r_rsp_data;
  assign bus.rsp_id    = r_rsp_id;
  assign bus.busy      = r_busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_a         <= '0;
      r_id        <= '0;
      r_last      <= ID_W'(NUM_REQ - 1);
      r_acc       <= '0;
      r_cnt       <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_id    <= '0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_grant) begin
            r_a     <= w_opnd;
            r_id    <= w_gidx;
            r_last  <= w_gidx;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= S_COMPUTE;
          end
        end
        S_COMPUTE: begin
          r_acc <= w_acc_nxt;
          r_cnt <= r_cnt + CNT_W'(1);
          if (r_cnt == CNT_W'(IN_W - 1)) begin
            r_rsp_data  <= w_acc_nxt;
            r_rsp_id    <= r_id;
            r_rsp_valid <= 1'b1;
            r_state     <= S_RESP;
          end
        end
        S_RESP: begin
          if (bus.rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_square_unit_arbiter.sv
// Directed bench for square_unit_arbiter.
// Inputs change 1ns after each rising edge; outputs sampled 1ns later.
module tb_square_unit_arbiter;
  logic clk;
  logic rst_n;
  int   n_err;
  int   n_chk;

  square_unit_arbiter_if #(.NUM_REQ(4), .IN_W(3), .ID_W(2)) bus ();

  square_unit_arbiter #(.NUM_REQ(4), .IN_W(3), .ID_W(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_op(input int idx, input int val);
    bus.req_data[idx*3 +: 3] = 3'(val);
  endtask

  // Grant in the current cycle, then fixed-latency response with
  // rsp_ready already high.
  task automatic serve(input logic [3:0] vld, input logic [3:0] vld_after,
                       input int gi, input int exp_d, input string tag);
    logic [3:0] seen;
    logic       early;
    bus.req_valid = vld;
    #1;
    chk({tag, ".grant"}, 32'(bus.req_ready), 32'(4'b0001 << gi));
    cyc();
    bus.req_valid = vld_after;
    seen  = '0;
    early = 1'b0;
    repeat (3) begin
      #1;
      seen  = seen | bus.req_ready;
      early = early | bus.rsp_valid;
      cyc();
    end
    #1;
    chk({tag, ".cmp_ready"}, 32'(seen), 0);
    chk({tag, ".early"}, 32'(early), 0);
    chk({tag, ".vld"}, 32'(bus.rsp_valid), 1);
    chk({tag, ".data"}, 32'(bus.rsp_data), 32'(exp_d));
    chk({tag, ".id"}, 32'(bus.rsp_id), 32'(gi));
    cyc();
    #1;
    chk({tag, ".idle"}, 32'(bus.busy), 0);
    chk({tag, ".vld0"}, 32'(bus.rsp_valid), 0);
  endtask

  initial begin
    logic       acc;
    n_err = 0;
    n_chk = 0;
    rst_n = 1'b0;
    bus.req_valid = 4'b1111;
    bus.req_data  = '0;
    bus.rsp_ready = 1'b0;

    cyc();
    cyc();
    #1;
    chk("rst.vld", 32'(bus.rsp_valid), 0);
    chk("rst.data", 32'(bus.rsp_data), 0);
    chk("rst.id", 32'(bus.rsp_id), 0);
    chk("rst.busy", 32'(bus.busy), 0);
    chk("rst.ready", 32'(bus.req_ready), 0);
    bus.req_valid = 4'b0000;
    cyc();
    rst_n = 1'b1;

    bus.rsp_ready = 1'b1;
    set_op(1, 5);
    serve(4'b0010, 4'b0000, 1, 25, "t1");

    for (int v = 0; v < 8; v++) begin
      set_op(0, v);
      serve(4'b0001, 4'b0000, 0, v * v, "t2");
    end

    rst_n = 1'b0;
    cyc();
    cyc();
    rst_n = 1'b1;
    set_op(0, 3);
    set_op(1, 2);
    set_op(2, 4);
    set_op(3, 6);
    serve(4'b1111, 4'b1111, 0, 9, "t3.0");
    serve(4'b1111, 4'b1111, 1, 4, "t3.1");
    serve(4'b1111, 4'b1111, 2, 16, "t3.2");
    serve(4'b1111, 4'b1111, 3, 36, "t3.3");
    serve(4'b1111, 4'b0000, 0, 9, "t3.4");

    bus.rsp_ready = 1'b0;
    set_op(2, 7);
    set_op(0, 0);
    bus.req_valid = 4'b0100;
    #1;
    chk("t4.grant", 32'(bus.req_ready), 32'(4'b0100));
    cyc();
    bus.req_valid = 4'b0001;
    repeat (3) cyc();
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("t4.hold_vld", 32'(bus.rsp_valid), 1);
      chk("t4.hold_data", 32'(bus.rsp_data), 49);
      chk("t4.hold_id", 32'(bus.rsp_id), 2);
      chk("t4.hold_ready", 32'(bus.req_ready), 0);
      cyc();
    end
    bus.rsp_ready = 1'b1;
    #1;
    chk("t4.hs_vld", 32'(bus.rsp_valid), 1);
    chk("t4.hs_ready", 32'(bus.req_ready), 0);
    cyc();
    #1;
    chk("t4.idle", 32'(bus.busy), 0);
    chk("t4.vld0", 32'(bus.rsp_valid), 0);
    chk("t4.keep_data", 32'(bus.rsp_data), 49);
    chk("t4.keep_id", 32'(bus.rsp_id), 2);
    serve(4'b0001, 4'b0000, 0, 0, "t4.zero");

    set_op(0, 5);
    bus.req_valid = 4'b0001;
    #1;
    chk("t5.grant", 32'(bus.req_ready), 32'(4'b0001));
    cyc();
    bus.req_valid = 4'b0000;
    cyc();
    rst_n = 1'b0;
    #1;
    chk("t5.vld", 32'(bus.rsp_valid), 0);
    chk("t5.busy", 32'(bus.busy), 0);
    chk("t5.ready", 32'(bus.req_ready), 0);
    cyc();
    rst_n = 1'b1;
    acc = 1'b0;
    repeat (6) begin
      #1;
      acc = acc | bus.rsp_valid | bus.busy;
      cyc();
    end
    chk("t5.no_rsp", 32'(acc), 0);
    set_op(0, 2);
    set_op(1, 3);
    set_op(2, 1);
    set_op(3, 6);
    serve(4'b0011, 4'b0010, 0, 4, "t5.rr");

    serve(4'b1110, 4'b1000, 1, 9, "t6.r1");
    serve(4'b1000, 4'b0000, 3, 36, "t6.r3");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
